calc_entry_fsm: RTL and testbench

- Operand/operator entry sequencer directly upstream of the 4-bit add/subtract stage.
- Collects key events (operand A, operator, operand B, equals) and drives registered, stable operands and an operator control to the adder.
- Captures the adder's combinational sum into a result register.
- Supports chained operations: the result becomes operand A when an operator key is pressed next.

---
 rtl/calc_entry_if.sv | 37 +++
 rtl/calc_entry_fsm.sv | 160 ++++++++++++++++
 tb/tb_calc_entry_fsm.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/calc_entry_if.sv
// Key/adder bus for calc_entry_fsm. The ovf signal exists only when CALC_OVF_FLAG_EN is defined.
interface calc_entry_if #(
  parameter int WIDTH = 4
);
  logic             key_valid;
  logic [1:0]       key_type;
  logic [WIDTH-1:0] key_data;
  logic             key_ready;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] opnd_b;
  logic             op_ctrl;
  logic [WIDTH-1:0] sum_in;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic [2:0]       state_o;
`ifdef CALC_OVF_FLAG_EN
  logic             ovf;

  modport master (
    output key_valid, key_type, key_data, sum_in,
    input  key_ready, opnd_a, opnd_b, op_ctrl, result, result_valid, state_o, ovf
  );
  modport slave (
    input  key_valid, key_type, key_data, sum_in,
    output key_ready, opnd_a, opnd_b, op_ctrl, result, result_valid, state_o, ovf
  );
`else
  modport master (
    output key_valid, key_type, key_data, sum_in,
    input  key_ready, opnd_a, opnd_b, op_ctrl, result, result_valid, state_o
  );
  modport slave (
    input  key_valid, key_type, key_data, sum_in,
    output key_ready, opnd_a, opnd_b, op_ctrl, result, result_valid, state_o
  );
`endif
endinterface

// File: rtl/calc_entry_fsm.sv
// Operand/operator entry sequencer feeding an external add/subtract stage and latching its result.
// Optional CALC_OVF_FLAG_EN adds a carry/borrow flag registered alongside the result.
module calc_entry_fsm #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  calc_entry_if.slave   bus
);

  typedef enum logic [2:0] {
    A_ENTRY = 3'b000,
    B_WAIT  = 3'b001,
    B_ENTRY = 3'b010,
    EXEC    = 3'b011,
    DONE    = 3'b100
  } state_t;

  typedef enum logic [1:0] {
    KEY_DIGIT  = 2'b00,
    KEY_PLUS   = 2'b01,
    KEY_MINUS  = 2'b10,
    KEY_EQUALS = 2'b11
  } key_t;

  state_t           r_state, w_nxt_state;
  logic [WIDTH-1:0] r_opnd_a, w_nxt_opnd_a;
  logic [WIDTH-1:0] r_opnd_b, w_nxt_opnd_b;
  logic             r_op_ctrl, w_nxt_op_ctrl;
  logic [WIDTH-1:0] r_result, w_nxt_result;
  logic             r_result_valid, w_nxt_result_valid;
  logic             w_key_ready;
  logic             w_accept;
  key_t             w_key;

`ifdef CALC_OVF_FLAG_EN
  logic             r_ovf, w_nxt_ovf;
  logic [WIDTH:0]   w_sum_wide;

  assign w_sum_wide = {1'b0, r_opnd_a} + {1'b0, r_opnd_b};
  assign bus.ovf    = r_ovf;
`endif

  assign w_key_ready = (r_state != EXEC);
  assign w_accept    = bus.key_valid && w_key_ready;
  assign w_key       = key_t'(bus.key_type);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_nxt_state        = r_state;
    w_nxt_opnd_a       = r_opnd_a;
    w_nxt_opnd_b       = r_opnd_b;
    w_nxt_op_ctrl      = r_op_ctrl;
    w_nxt_result       = r_result;
    w_nxt_result_valid = r_result_valid;
`ifdef CALC_OVF_FLAG_EN
    w_nxt_ovf          = r_ovf;
`endif
    case (r_state)
      A_ENTRY: if (w_accept) begin
        case (w_key)
          KEY_DIGIT:  w_nxt_opnd_a = bus.key_data;
          KEY_PLUS,
          KEY_MINUS: begin
            w_nxt_op_ctrl = (w_key == KEY_PLUS);
            w_nxt_state   = B_WAIT;
          end
          default: ;
        endcase
      end
      B_WAIT: if (w_accept) begin
        case (w_key)
          KEY_DIGIT: begin
            w_nxt_opnd_b = bus.key_data;
            w_nxt_state  = B_ENTRY;
          end
          KEY_PLUS,
          KEY_MINUS:  w_nxt_op_ctrl = (w_key == KEY_PLUS);
          default: ;
        endcase
      end
      B_ENTRY: if (w_accept) begin
        case (w_key)
          KEY_DIGIT:  w_nxt_opnd_b  = bus.key_data;
          KEY_PLUS,
          KEY_MINUS:  w_nxt_op_ctrl = (w_key == KEY_PLUS);
          default:    w_nxt_state   = EXEC;
        endcase
      end
      // Operands are frozen here, so sum_in has settled by the closing edge.
      EXEC: begin
        w_nxt_result       = bus.sum_in;
        w_nxt_result_valid = 1'b1;
        w_nxt_state        = DONE;
`ifdef CALC_OVF_FLAG_EN
        w_nxt_ovf          = r_op_ctrl ? w_sum_wide[WIDTH] : (r_opnd_b > r_opnd_a);
`endif
      end
      DONE: if (w_accept) begin
        w_nxt_result_valid = 1'b0;
`ifdef CALC_OVF_FLAG_EN
        w_nxt_ovf          = 1'b0;
`endif
        case (w_key)
          KEY_DIGIT: begin
            w_nxt_opnd_a = bus.key_data;
            w_nxt_opnd_b = '0;
            w_nxt_state  = A_ENTRY;
          end
          KEY_PLUS,
          KEY_MINUS: begin
            w_nxt_opnd_a  = r_result;
            w_nxt_op_ctrl = (w_key == KEY_PLUS);
            w_nxt_state   = B_WAIT;
          end
          default: begin
            w_nxt_opnd_a = r_result;
            w_nxt_state  = EXEC;
          end
        endcase
      end
      default: w_nxt_state = A_ENTRY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; rst outranks clr, and both outrank keys.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state        <= A_ENTRY;
      r_opnd_a       <= '0;
      r_opnd_b       <= '0;
      r_op_ctrl      <= 1'b1;
      r_result       <= '0;
      r_result_valid <= 1'b0;
`ifdef CALC_OVF_FLAG_EN
      r_ovf          <= 1'b0;
`endif
    end else begin
      r_state        <= w_nxt_state;
      r_opnd_a       <= w_nxt_opnd_a;
      r_opnd_b       <= w_nxt_opnd_b;
      r_op_ctrl      <= w_nxt_op_ctrl;
      r_result       <= w_nxt_result;
      r_result_valid <= w_nxt_result_valid;
`ifdef CALC_OVF_FLAG_EN
      r_ovf          <= w_nxt_ovf;
`endif
    end
  end

  assign bus.key_ready    = w_key_ready;
  assign bus.opnd_a       = r_opnd_a;
  assign bus.opnd_b       = r_opnd_b;
  assign bus.op_ctrl      = r_op_ctrl;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.state_o      = r_state;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Self-checking bench for calc_entry_fsm: plays keypad and 4-bit adder, scoreboards each result.
module tb_calc_entry_fsm;
  localparam int WIDTH = 4;
  localparam logic [1:0] K_DIG = 2'b00, K_PLUS = 2'b01, K_MINUS = 2'b10, K_EQ = 2'b11;

  typedef struct {
    int unsigned res;
    int unsigned ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  logic r_prev_valid = 1'b0;

  calc_entry_if #(.WIDTH(WIDTH)) bus ();

  calc_entry_fsm #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Downstream adder: combinational, wraps modulo 2^WIDTH.
  assign bus.sum_in = bus.op_ctrl ? (bus.opnd_a + bus.opnd_b) : (bus.opnd_a - bus.opnd_b);

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Offer one key for exactly one cycle, returning at the next falling edge.
  task automatic key(input logic [1:0] t, input int unsigned d);
    bus.key_valid = 1'b1;
    bus.key_type  = t;
    bus.key_data  = WIDTH'(d);
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  task automatic push(input int unsigned res, input int unsigned ovf);
    exp_t e;
    e.res = res % 16;
    e.ovf = ovf;
    sb_q.push_back(e);
  endtask

  // Pop and compare whenever result_valid rises.
  always @(negedge clk) begin
    if (bus.result_valid && !r_prev_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_result", bus.result, e.res);
`ifdef CALC_OVF_FLAG_EN
        check("sb_ovf", bus.ovf, e.ovf);
`endif
      end
    end
    r_prev_valid <= bus.result_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, bus.state_o, 0);
    check({tag, "_a"}, bus.opnd_a, 0);
    check({tag, "_b"}, bus.opnd_b, 0);
    check({tag, "_ctrl"}, bus.op_ctrl, 1);
    check({tag, "_result"}, bus.result, 0);
    check({tag, "_valid"}, bus.result_valid, 0);
    check({tag, "_ready"}, bus.key_ready, 1);
`ifdef CALC_OVF_FLAG_EN
    check({tag, "_ovf"}, bus.ovf, 0);
`endif
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_type  = K_DIG;
    bus.key_data  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_values("rst");

    // Basic add: 3 + 4
    key(K_DIG, 3);   check("add_a", bus.opnd_a, 3);
    key(K_PLUS, 0);  check("add_state_bwait", bus.state_o, 1);
    key(K_DIG, 4);   check("add_b", bus.opnd_b, 4); check("add_state_bentry", bus.state_o, 2);
    key(K_EQ, 0);    push(3 + 4, 0);
    check("add_state_exec", bus.state_o, 3);
    check("add_ready_exec", bus.key_ready, 0);
    check("add_ctrl", bus.op_ctrl, 1);
    @(negedge clk);
    check("add_state_done", bus.state_o, 4);
    check("add_valid", bus.result_valid, 1);

    // Subtract with wrap: 2 - 5
    key(K_DIG, 2);
    check("sub_state_a", bus.state_o, 0);
    check("sub_b_cleared", bus.opnd_b, 0);
    check("sub_valid_cleared", bus.result_valid, 0);
    key(K_MINUS, 0);
    key(K_DIG, 5);
    key(K_EQ, 0);    push(16 + 2 - 5, 1);
    check("sub_ctrl", bus.op_ctrl, 0);
    @(negedge clk);

    // Chaining and repeat-equals
    key(K_DIG, 9); key(K_PLUS, 0); key(K_DIG, 9);
    key(K_EQ, 0);    push(9 + 9, 1);
    @(negedge clk);
    key(K_PLUS, 0);
    check("chain_a", bus.opnd_a, 2);
    check("chain_state", bus.state_o, 1);
    key(K_DIG, 1);
    key(K_EQ, 0);    push(2 + 1, 0);
    @(negedge clk);
    key(K_EQ, 0);    push(3 + 1, 0);
    check("repeat_state", bus.state_o, 3);
    check("repeat_a", bus.opnd_a, 3);
    check("repeat_b", bus.opnd_b, 1);
    @(negedge clk);

    // Key held through EXEC is dropped, then accepted in DONE
    key(K_DIG, 1); key(K_PLUS, 0); key(K_DIG, 1);
    key(K_EQ, 0);    push(1 + 1, 0);
    bus.key_valid = 1'b1; bus.key_type = K_DIG; bus.key_data = 4'd7;
    check("hold_ready_exec", bus.key_ready, 0);
    @(negedge clk);
    check("hold_state_done", bus.state_o, 4);
    check("hold_dropped_a", bus.opnd_a, 1);
    check("hold_ready_done", bus.key_ready, 1);
    @(negedge clk);
    bus.key_valid = 1'b0;
    check("hold_state_a", bus.state_o, 0);
    check("hold_a", bus.opnd_a, 7);
    check("hold_valid", bus.result_valid, 0);

    // Edge keys
    key(K_EQ, 0);    check("eq_in_aentry", bus.state_o, 0);
    key(K_PLUS, 0);
    key(K_EQ, 0);    check("eq_in_bwait", bus.state_o, 1);
    key(K_MINUS, 0); check("minus_in_bwait_ctrl", bus.op_ctrl, 0);
    check("minus_in_bwait_state", bus.state_o, 1);

    // Clear during EXEC, with a key also offered
    key(K_DIG, 3);
    key(K_EQ, 0);
    check("clr_pre_state", bus.state_o, 3);
    clr = 1'b1;
    bus.key_valid = 1'b1; bus.key_type = K_DIG; bus.key_data = 4'd5;
    @(negedge clk);
    clr = 1'b0; bus.key_valid = 1'b0;
    check_reset_values("clr");

    // Reset during EXEC
    key(K_DIG, 6); key(K_PLUS, 0); key(K_DIG, 2);
    key(K_EQ, 0);
    check("rst_pre_state", bus.state_o, 3);
    rst = 1'b1;
    bus.key_valid = 1'b1; bus.key_type = K_PLUS;
    @(negedge clk);
    rst = 1'b0; bus.key_valid = 1'b0;
    check_reset_values("rst_exec");

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
